avalon_st_enforcer: RTL and testbench

Protocol guard between an untrusted Avalon-ST source and a downstream sink. It forwards data with zero latency and repairs framing violations: out-of-packet beats are dropped, a repeated SOP is masked, and EMPTY is cleared on non-EOP beats. One-cycle indication pulses report each violation. It sits at the ingress boundary of any pipeline fed by an external or unverified streaming source.

---
 rtl/avalon_st_enforcer_if.sv | 16 +
 rtl/avalon_st_enforcer.sv | 92 +++++++++
 tb/tb_avalon_st_enforcer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/avalon_st_enforcer_if.sv
// Avalon-ST stream bundle shared by the untrusted source and the enforced sink.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;
  logic                             rdy;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_enforcer.sv
// Zero-latency Avalon-ST framing guard: drops out-of-packet beats, masks a
// repeated SOP, clears EMPTY on non-EOP beats and pulses a flag per violation.
module avalon_st_enforcer #(
  parameter int DATA_WIDTH_IN_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  untrusted,
  avalon_st_if.master enforced,
  output logic        valid_out_of_packet,
  output logic        second_sop_indc
);

  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               oop_q, oop_d;
  logic               ssop_q, ssop_d;
  logic               accept;
  logic               fwd;
  logic               fwd_sop;
  logic               fwd_eop;
  logic [EMPTY_W-1:0] fwd_empty;

  // A beat only moves when the sink can take it; ready passes straight through.
  assign accept = untrusted.valid & enforced.rdy;

  // Forwarding decision follows valid (so the sink sees a stable beat under
  // backpressure); state and flags only advance on an accepted beat.
  always_comb begin
    state_d   = state_q;
    fwd       = 1'b0;
    fwd_sop   = 1'b0;
    oop_d     = 1'b0;
    ssop_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (untrusted.valid && untrusted.sop) begin
          fwd     = 1'b1;
          fwd_sop = 1'b1;
        end
        if (accept) begin
          if (untrusted.sop) begin
            if (!untrusted.eop) state_d = IN_PKT;
          end else begin
            oop_d = 1'b1;
          end
        end
      end
      IN_PKT: begin
        fwd = untrusted.valid;
        if (accept) begin
          if (untrusted.sop) ssop_d  = 1'b1;
          if (untrusted.eop) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fwd_eop   = fwd & untrusted.eop;
  assign fwd_empty = fwd_eop ? untrusted.empty : '0;

  assign untrusted.rdy  = enforced.rdy;
  assign enforced.data  = untrusted.data;
  assign enforced.valid = fwd;
  assign enforced.sop   = fwd_sop;
  assign enforced.eop   = fwd_eop;
  assign enforced.empty = fwd_empty;

  // Packet state and one-cycle violation pulses; reset abandons any open packet.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      oop_q   <= 1'b0;
      ssop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      oop_q   <= oop_d;
      ssop_q  <= ssop_d;
    end
  end

  assign valid_out_of_packet = oop_q;
  assign second_sop_indc     = ssop_q;

endmodule

// File: tb/tb_avalon_st_enforcer.sv
// Bench for avalon_st_enforcer: directed framing scenarios then random beats,
// each compared against a packet-level reference model.
module tb_avalon_st_enforcer;

  localparam int NB = 16;
  localparam int DW = 8 * NB;

  logic clk;
  logic rst;
  logic valid_out_of_packet;
  logic second_sop_indc;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) u_in  ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) u_out ();

  avalon_st_enforcer #(.DATA_WIDTH_IN_BYTES(NB)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .untrusted           (u_in),
    .enforced            (u_out),
    .valid_out_of_packet (valid_out_of_packet),
    .second_sop_indc     (second_sop_indc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit pkt_open = 1'b0;   // reference: is a packet currently open at the sink?

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive a beat, check the combinational outputs, then the flags after the edge.
  task automatic step(input string tag, input logic v, input logic s, input logic e,
                      input logic [3:0] emp, input logic r, input logic [DW-1:0] d);
    bit fwd, acc, exp_oop, exp_ssop;
    @(negedge clk);
    u_in.valid = v; u_in.sop = s; u_in.eop = e; u_in.empty = emp; u_in.data = d;
    u_out.rdy  = r;
    #1;
    fwd      = v && (pkt_open || s);
    acc      = v && r;
    exp_oop  = acc && !pkt_open && !s;
    exp_ssop = acc && pkt_open && s;
    check({tag, ".rdy"},   DW'(u_in.rdy),    DW'(r));
    check({tag, ".valid"}, DW'(u_out.valid), DW'(fwd));
    check({tag, ".sop"},   DW'(u_out.sop),   DW'(fwd && s && !pkt_open));
    check({tag, ".eop"},   DW'(u_out.eop),   DW'(fwd && e));
    check({tag, ".empty"}, DW'(u_out.empty), (fwd && e) ? DW'(emp) : '0);
    check({tag, ".data"},  u_out.data,       d);
    @(posedge clk);
    #1;
    if (acc && (pkt_open || s)) pkt_open = !e;
    check({tag, ".oop"},  DW'(valid_out_of_packet), DW'(exp_oop));
    check({tag, ".ssop"}, DW'(second_sop_indc),     DW'(exp_ssop));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0; u_in.valid = 1'b0;
    @(posedge clk);
    #1;
    pkt_open = 1'b0;
    check({tag, ".oop"},  DW'(valid_out_of_packet), '0);
    check({tag, ".ssop"}, DW'(second_sop_indc),     '0);
    check({tag, ".valid"}, DW'(u_out.valid),        '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] d22;
    d22 = {NB{8'h22}};
    rst = 1'b0;
    u_in.valid = 1'b0; u_in.sop = 1'b0; u_in.eop = 1'b0; u_in.empty = '0; u_in.data = '0;
    u_out.rdy = 1'b1;
    do_reset("reset");

    // nominal three-beat packet
    step("nom_b1", 1, 1, 0, 0, 1, d22);
    step("nom_b2", 1, 0, 0, 0, 1, d22);
    step("nom_b3", 1, 0, 1, 1, 1, d22);
    // single-beat packet, then an ordinary beat must still be stray
    step("single", 1, 1, 1, 1, 1, rnd_data());
    step("idle",   0, 0, 0, 0, 1, rnd_data());
    step("stray",  1, 0, 0, 0, 1, rnd_data());
    step("stray2", 1, 0, 1, 3, 1, rnd_data());
    // double SOP inside a packet
    step("dsop_b1", 1, 1, 0, 0, 1, rnd_data());
    step("dsop_b2", 1, 0, 0, 0, 1, rnd_data());
    step("dsop_b3", 1, 1, 0, 0, 1, rnd_data());
    step("dsop_b4", 1, 0, 0, 0, 1, rnd_data());
    step("dsop_b5", 1, 0, 1, 2, 1, rnd_data());
    step("dsop_after", 1, 0, 0, 0, 1, rnd_data());
    // gapped packet
    step("gap_sop", 1, 1, 0, 0, 1, rnd_data());
    step("gap_1",   0, 0, 0, 0, 1, rnd_data());
    step("gap_2",   0, 1, 1, 5, 1, rnd_data());
    step("gap_eop", 1, 0, 1, 4, 1, rnd_data());
    // early empty on non-EOP beat
    step("ee_sop", 1, 1, 0, 7, 1, rnd_data());
    step("ee_mid", 1, 0, 0, 1, 1, rnd_data());
    step("ee_eop", 1, 0, 1, 1, 1, rnd_data());
    // backpressure: stray beat and second SOP held, then released
    step("bp_stray_hold", 1, 0, 0, 0, 0, rnd_data());
    step("bp_stray_go",   1, 0, 0, 0, 1, rnd_data());
    step("bp_sop",        1, 1, 0, 0, 1, rnd_data());
    step("bp_ssop_hold",  1, 1, 1, 3, 0, rnd_data());
    step("bp_ssop_hold2", 1, 1, 1, 3, 0, rnd_data());
    step("bp_ssop_go",    1, 1, 1, 3, 1, rnd_data());
    // reset mid-packet abandons it
    step("rst_sop", 1, 1, 0, 0, 1, rnd_data());
    do_reset("rst_mid");
    step("rst_after", 1, 0, 1, 0, 1, rnd_data());
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), 4'($urandom), ($urandom_range(0, 4) != 0),
           rnd_data());
      if (i == 200) do_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
